// File: rtl/spi_pkg.sv
// Register map, CTRL bit layout, FSM states and read opcode shared by the
// flash-read sequencer and anything that talks to the same SPI master.
package spi_pkg;

  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_DATA   = 32'h0000_0004;
  localparam logic [31:0] REG_STATUS = 32'h0000_0008;

  localparam int CTRL_START = 0;
  localparam int CTRL_CPOL  = 1;
  localparam int CTRL_CPHA  = 2;
  localparam int CTRL_SEL   = 3;
  localparam int CTRL_DIV   = 8;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [2:0] HDR_LEN  = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    SEL,
    LOAD,
    KICK,
    WAIT,
    POLL,
    CAPT,
    OUT,
    DESEL,
    FIN
  } state_t;

  function automatic logic [31:0] ctrl_word(input logic [7:0] div,
                                            input logic       sel,
                                            input logic       cpha,
                                            input logic       cpol,
                                            input logic       start);
    logic [31:0] w;
    w                 = '0;
    w[CTRL_DIV +: 8]  = div;
    w[CTRL_SEL]       = sel;
    w[CTRL_CPHA]      = cpha;
    w[CTRL_CPOL]      = cpol;
    w[CTRL_START]     = start;
    return w;
  endfunction

endpackage

// File: rtl/spi_flash_rd.sv
// Drives a register-mapped SPI master through a flash READ: opcode, 24-bit
// address, then one dummy byte per data byte, streaming the returned bytes out.
module spi_flash_rd #(
  parameter logic [7:0] DIV      = 8'd0,
  parameter logic       CPOL     = 1'b0,
  parameter logic       CPHA     = 1'b0,
  parameter logic [7:0] CMD_READ = spi_pkg::CMD_READ
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] flash_addr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic [31:0] spi_addr_o,
  output logic [31:0] spi_wdata_o,
  output logic        spi_we_o,
  input  logic [31:0] spi_rdata_i
);
  import spi_pkg::*;

  localparam logic [31:0] CTRL_SELECT = ctrl_word(DIV, 1'b1, CPHA, CPOL, 1'b0);
  localparam logic [31:0] CTRL_KICK   = ctrl_word(DIV, 1'b1, CPHA, CPOL, 1'b1);
  localparam logic [31:0] CTRL_DESEL  = ctrl_word(DIV, 1'b0, CPHA, CPOL, 1'b0);

  state_t      state;
  logic [23:0] addr_q;
  logic [15:0] remain;
  logic [2:0]  hdr_idx;
  logic [1:0]  wait_cnt;

  // Only the low byte of DATA and bit 0 of STATUS carry information.
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata_i[31:8];

  // Byte shifted out at position idx; past the header every byte is a dummy.
  function automatic logic [7:0] tx_byte(input logic [2:0]  idx,
                                         input logic [23:0] a);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_READ;
      3'd1:    b = a[23:16];
      3'd2:    b = a[15:8];
      3'd3:    b = a[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Outputs are loaded on the transition, so they hold for the state being entered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'h00;
      spi_we_o     <= 1'b0;
      spi_addr_o   <= 32'h0;
      spi_wdata_o  <= 32'h0;
      addr_q       <= 24'h0;
      remain       <= 16'h0;
      hdr_idx      <= 3'd0;
      wait_cnt     <= 2'd0;
    end else begin
      spi_we_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (len_i != 16'd0) begin
              addr_q      <= flash_addr_i;
              remain      <= len_i;
              hdr_idx     <= 3'd0;
              state       <= SEL;
              spi_we_o    <= 1'b1;
              spi_addr_o  <= REG_CTRL;
              spi_wdata_o <= CTRL_SELECT;
            end else begin
              state <= FIN;
            end
          end
        end
        SEL: begin
          state       <= LOAD;
          spi_we_o    <= 1'b1;
          spi_addr_o  <= REG_DATA;
          spi_wdata_o <= {24'h0, tx_byte(hdr_idx, addr_q)};
        end
        LOAD: begin
          state       <= KICK;
          spi_we_o    <= 1'b1;
          spi_addr_o  <= REG_CTRL;
          spi_wdata_o <= CTRL_KICK;
        end
        KICK: begin
          state      <= WAIT;
          wait_cnt   <= 2'd0;
          spi_addr_o <= REG_STATUS;
        end
        // The master's busy flag lags the kick; polling early would see idle.
        WAIT: begin
          if (wait_cnt == 2'd2) begin
            state <= POLL;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        POLL: begin
          if (!spi_rdata_i[0]) begin
            state      <= CAPT;
            spi_addr_o <= REG_DATA;
          end
        end
        CAPT: begin
          if (hdr_idx != HDR_LEN) begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == HDR_LEN - 3'd1 && remain == 16'd0) begin
              state       <= DESEL;
              spi_we_o    <= 1'b1;
              spi_addr_o  <= REG_CTRL;
              spi_wdata_o <= CTRL_DESEL;
            end else begin
              state       <= LOAD;
              spi_we_o    <= 1'b1;
              spi_addr_o  <= REG_DATA;
              spi_wdata_o <= {24'h0, tx_byte(hdr_idx + 3'd1, addr_q)};
            end
          end else begin
            byte_o       <= spi_rdata_i[7:0];
            byte_valid_o <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (byte_ready_i) begin
            byte_valid_o <= 1'b0;
            remain       <= remain - 16'd1;
            spi_we_o     <= 1'b1;
            if (remain == 16'd1) begin
              state       <= DESEL;
              spi_addr_o  <= REG_CTRL;
              spi_wdata_o <= CTRL_DESEL;
            end else begin
              state       <= LOAD;
              spi_addr_o  <= REG_DATA;
              spi_wdata_o <= {24'h0, tx_byte(hdr_idx, addr_q)};
            end
          end
        end
        DESEL: begin
          state <= FIN;
        end
        FIN: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench for spi_flash_rd: byte-level SPI master + flash model behind the
// register port, with a DIV=0 and a DIV=3 instance.
module tb_spi_flash_rd;
  localparam int NI = 2;

  logic        clk;
  logic        rst_n;
  logic        start  [NI];
  logic [23:0] faddr  [NI];
  logic [15:0] len    [NI];
  logic        busy   [NI];
  logic        done   [NI];
  logic [7:0]  bout   [NI];
  logic        bvalid [NI];
  logic        bready [NI];
  logic [31:0] saddr  [NI];
  logic [31:0] swdata [NI];
  logic        swe    [NI];
  logic [31:0] srdata [NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_flash_rd #(.DIV(8'd0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .flash_addr_i(faddr[0]),
    .len_i(len[0]), .busy_o(busy[0]), .done_o(done[0]), .byte_o(bout[0]),
    .byte_valid_o(bvalid[0]), .byte_ready_i(bready[0]), .spi_addr_o(saddr[0]),
    .spi_wdata_o(swdata[0]), .spi_we_o(swe[0]), .spi_rdata_i(srdata[0]));

  spi_flash_rd #(.DIV(8'd3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .flash_addr_i(faddr[1]),
    .len_i(len[1]), .busy_o(busy[1]), .done_o(done[1]), .byte_o(bout[1]),
    .byte_valid_o(bvalid[1]), .byte_ready_i(bready[1]), .spi_addr_o(saddr[1]),
    .spi_wdata_o(swdata[1]), .spi_we_o(swe[1]), .spi_rdata_i(srdata[1]));

  // ---------------- SPI master + flash model ----------------
  logic [7:0]  mem [0:511];
  logic        m_sel  [NI];
  logic        m_busy [NI];
  logic [7:0]  m_data [NI];
  logic [7:0]  m_res  [NI];
  logic [7:0]  m_div  [NI];
  logic [31:0] m_ctrl [NI];
  logic [23:0] m_fa   [NI];
  int          m_lat  [NI];
  int          m_cnt  [NI];
  int          m_k    [NI];
  int          wr_cnt [NI] = '{default: 0};
  int          wr_viol = 0;
  logic [7:0]  mosi_q [$];

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      srdata[i] = 32'h0;
      case (saddr[i])
        32'h0:   srdata[i] = m_ctrl[i];
        32'h4:   srdata[i] = {24'h0, m_data[i]};
        32'h8:   srdata[i] = {31'h0, m_busy[i]};
        default: srdata[i] = 32'hDEAD_BEEF;
      endcase
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_sel[i]  <= 1'b0;
        m_busy[i] <= 1'b0;
        m_data[i] <= 8'h00;
        m_res[i]  <= 8'h00;
        m_div[i]  <= 8'h00;
        m_ctrl[i] <= 32'h0;
        m_fa[i]   <= 24'h0;
        m_lat[i]  <= 0;
        m_cnt[i]  <= 0;
        m_k[i]    <= 0;
      end else begin
        if (m_lat[i] > 0) begin
          m_lat[i] <= m_lat[i] - 1;
          if (m_lat[i] == 1) m_busy[i] <= 1'b1;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_busy[i] <= 1'b0;
            m_data[i] <= m_res[i];
          end
        end
        if (swe[i]) begin
          wr_cnt[i] <= wr_cnt[i] + 1;
          if (m_busy[i] || m_lat[i] != 0 || m_cnt[i] != 0) wr_viol <= wr_viol + 1;
          if (saddr[i] == 32'h0) begin
            m_ctrl[i] <= {swdata[i][31:1], 1'b0};
            m_sel[i]  <= swdata[i][3];
            m_div[i]  <= swdata[i][15:8];
            if (swdata[i][3] && !m_sel[i]) m_k[i] <= 0;
            if (swdata[i][3] && swdata[i][0]) begin
              mosi_q.push_back(m_data[i]);
              if (m_k[i] >= 1 && m_k[i] <= 3) m_fa[i] <= {m_fa[i][15:0], m_data[i]};
              if (m_k[i] < 4) m_res[i] <= 8'hFF;
              else m_res[i] <= mem[m_fa[i][8:0] + 9'(m_k[i] - 4)];
              m_k[i]   <= m_k[i] + 1;
              m_lat[i] <= 2;
              m_cnt[i] <= 16 * (int'(swdata[i][15:8]) + 1);
            end
          end else if (saddr[i] == 32'h4) begin
            m_data[i] <= swdata[i][7:0];
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_q [$];
  int done_cnt [NI] = '{default: 0};
  int busy_cyc [NI] = '{default: 0};
  int done_sel_bad = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_n && bvalid[i] && bready[i]) got_q.push_back(bout[i]);
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        if (m_sel[i]) done_sel_bad <= done_sel_bad + 1;
      end
      if (busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  typedef struct {
    int          inst;
    logic [23:0] addr;
    logic [15:0] len;
    int          stall_idx;
    int          stall_cyc;
    bit          repulse;
    logic [3:0][7:0] exp;
    logic [7:0]  div;
  } vec_t;

  function automatic vec_t mk(input int inst, input logic [23:0] addr, input logic [15:0] n,
                              input int sidx, input int scyc, input bit rp,
                              input logic [31:0] e, input logic [7:0] div);
    vec_t v;
    v.inst = inst; v.addr = addr; v.len = n; v.stall_idx = sidx; v.stall_cyc = scyc;
    v.repulse = rp; v.exp = e; v.div = div;
    return v;
  endfunction

  logic [7:0] exp_q [$];

  task automatic run_txn(input string tag, input vec_t v, output int dur);
    int i, g0, m0, w0, d0, b0, s0, n, stalled, hold, sbad, hw;
    logic [7:0] hb;
    logic [7:0] em [$];
    i = v.inst;
    g0 = got_q.size(); m0 = mosi_q.size(); w0 = wr_cnt[i];
    d0 = done_cnt[i]; b0 = busy_cyc[i]; s0 = done_sel_bad;
    for (int j = 0; j < int'(v.len); j++) exp_q.push_back(v.exp[j]);
    em.push_back(8'h03); em.push_back(v.addr[23:16]);
    em.push_back(v.addr[15:8]); em.push_back(v.addr[7:0]);
    for (int j = 0; j < int'(v.len); j++) em.push_back(8'h00);
    stalled = 0; hold = 0; sbad = 0; hw = 0; hb = 8'h00;

    @(posedge clk); #1;
    start[i] = 1'b1; faddr[i] = v.addr; len[i] = v.len;
    n = 0;
    while (done_cnt[i] == d0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (v.repulse && n == 6) begin
        start[i] = 1'b1; faddr[i] = 24'hABCDEF; len[i] = 16'd2;
      end else begin
        start[i] = 1'b0; faddr[i] = 24'hFFFFFF; len[i] = 16'hFFFF;
      end
      if (v.stall_cyc > 0 && stalled == 0 && got_q.size() - g0 == v.stall_idx) begin
        bready[i] = 1'b0;
        stalled = 1;
      end else if (stalled == 1 && bvalid[i]) begin
        if (hold == 0) begin
          hb = bout[i]; hw = wr_cnt[i];
        end else if (bout[i] !== hb) begin
          sbad++;
        end
        hold++;
        if (hold == v.stall_cyc) begin
          check({tag, "_stall_byte_stable"}, 64'(sbad), 64'd0);
          check({tag, "_stall_no_spi"}, 64'(wr_cnt[i] - hw), 64'd0);
          bready[i] = 1'b1;
          stalled = 2;
        end
      end
    end
    check({tag, "_finished"}, 64'(done_cnt[i] != d0), 64'd1);
    bready[i] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt[i] - d0), 64'd1);
    check({tag, "_byte_count"}, 64'(got_q.size() - g0), 64'(v.len));
    for (int j = 0; j < int'(v.len); j++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (g0 + j < got_q.size()) check($sformatf("%s_byte%0d", tag, j), 64'(got_q[g0 + j]), 64'(e));
      else check($sformatf("%s_byte%0d", tag, j), 64'hFFFF, 64'(e));
    end
    check({tag, "_mosi_count"}, 64'(mosi_q.size() - m0), 64'(em.size()));
    for (int j = 0; j < em.size(); j++) begin
      if (m0 + j < mosi_q.size()) check($sformatf("%s_mosi%0d", tag, j), 64'(mosi_q[m0 + j]), 64'(em[j]));
    end
    check({tag, "_write_count"}, 64'(wr_cnt[i] - w0), 64'(2 + 2 * em.size()));
    check({tag, "_desel_before_done"}, 64'(done_sel_bad - s0), 64'd0);
    check({tag, "_idle_after"}, 64'(busy[i]), 64'd0);
    check({tag, "_ctrl_div"}, 64'(m_div[i]), 64'(v.div));
    dur = busy_cyc[i] - b0;
  endtask

  task automatic check_reset(input string tag, input int i);
    check({tag, "_busy"}, 64'(busy[i]), 64'd0);
    check({tag, "_done"}, 64'(done[i]), 64'd0);
    check({tag, "_valid"}, 64'(bvalid[i]), 64'd0);
    check({tag, "_byte"}, 64'(bout[i]), 64'd0);
    check({tag, "_we"}, 64'(swe[i]), 64'd0);
    check({tag, "_addr"}, 64'(saddr[i]), 64'd0);
    check({tag, "_wdata"}, 64'(swdata[i]), 64'd0);
  endtask

  vec_t vecs [4];

  initial begin
    int d0, d2, dz, w0, g0, n;
    for (int a = 0; a < 512; a++) mem[a] = 8'(a) ^ 8'h3C;
    mem[9'h100] = 8'h11; mem[9'h101] = 8'h22; mem[9'h102] = 8'h33; mem[9'h103] = 8'h44;
    mem[9'h1F0] = 8'hA0; mem[9'h1F1] = 8'hA1; mem[9'h1F2] = 8'hA2;
    mem[9'h000] = 8'h5A;

    vecs[0] = mk(0, 24'h000100, 16'd4, 0, 0,  1'b1, 32'h44332211, 8'd0);
    vecs[1] = mk(0, 24'h000100, 16'd4, 1, 20, 1'b0, 32'h44332211, 8'd0);
    vecs[2] = mk(1, 24'h000100, 16'd4, 0, 0,  1'b0, 32'h44332211, 8'd3);
    vecs[3] = mk(0, 24'h0001F0, 16'd3, 0, 0,  1'b0, 32'h00A2A1A0, 8'd0);

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; faddr[i] = 24'h0; len[i] = 16'h0; bready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0", 0);
    check_reset("rst3", 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    d0 = 0; d2 = 0; dz = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn($sformatf("v%0d", k), vecs[k], dz);
      if (k == 0) d0 = dz;
      if (k == 2) d2 = dz;
    end
    check("div3_longer_poll", 64'(d2 > d0), 64'd1);

    // zero-length request: straight to FIN, no bus traffic
    w0 = wr_cnt[0];
    @(posedge clk); #1;
    start[0] = 1'b1; len[0] = 16'd0; faddr[0] = 24'h000100;
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("len0_busy_c1", 64'({busy[0], done[0]}), 64'b10);
    @(posedge clk); #1;
    check("len0_done_c2", 64'({busy[0], done[0]}), 64'b01);
    @(posedge clk); #1;
    check("len0_done_pulse", 64'(done[0]), 64'd0);
    check("len0_no_writes", 64'(wr_cnt[0] - w0), 64'd0);

    // reset in the middle of the data phase, then a fresh one-byte read
    g0 = got_q.size();
    @(posedge clk); #1;
    start[0] = 1'b1; faddr[0] = 24'h000100; len[0] = 16'd4;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (got_q.size() == g0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reached_data", 64'(got_q.size() > g0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("midrst", 0);
    repeat (2) @(posedge clk);
    run_txn("after_rst", mk(0, 24'h000000, 16'd1, 0, 0, 1'b0, 32'h0000005A, 8'd0), dz);

    check("no_write_while_master_busy", 64'(wr_viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_rd.md
SPI_FLASH_RD -- requirements
Module: spi_flash_rd

Interface
REQ-001 Parameter DIV, default 8'd0, SPI clock divider written to SPI_CTRL[15:8].
REQ-002 Parameter CPOL, default 1'b0, written to SPI_CTRL[1].
REQ-003 Parameter CPHA, default 1'b0, written to SPI_CTRL[2].
REQ-004 Parameter CMD_READ, default 8'h03, flash read opcode.
REQ-005 Single clock; reset is synchronous and active-low: clk_i  input  1  clock; rst_ni  input  1  reset.
REQ-006 Request ports: start_i  input  1  start pulse; flash_addr_i  input  24  byte address; len_i  input  16  byte count.
REQ-007 Status ports: busy_o  output  1  transaction active; done_o  output  1  one-cycle completion pulse.
REQ-008 Stream ports: byte_o  output  8  read byte; byte_valid_o  output  1  byte valid; byte_ready_i  input  1  consumer ready.
REQ-009 SPI-master register port: spi_addr_o  output  32  register offset; spi_wdata_o  output  32  write data; spi_we_o  output  1  write strobe; spi_rdata_i  input  32  combinational read data.

Function
REQ-010 Register offsets SHALL be: CTRL 0x0 (bit0 start, self-clearing; bit1 CPOL; bit2 CPHA; bit3 select; [15:8] div), DATA 0x4 (byte in [7:0]), STATUS 0x8 (bit0 busy).
REQ-011 FSM states SHALL be IDLE, SEL, LOAD, KICK, WAIT, POLL, CAPT, OUT, DESEL, FIN.
REQ-012 IDLE: start_i with len_i!=0 latches address and length, goes to SEL; start_i with len_i==0 goes to FIN; start_i while busy_o is set SHALL be ignored.
REQ-013 SEL: writes CTRL = {div, select=1, CPHA, CPOL, start=0}, then goes to LOAD.
REQ-014 Byte order SHALL be CMD_READ, then addr[23:16], addr[15:8], addr[7:0], then len dummy bytes of 8'h00; a 16-bit phase counter plus a 3-bit header index track position.
REQ-015 LOAD: writes DATA with the current byte. KICK: writes CTRL with select=1 and start=1.
REQ-016 WAIT: holds spi_we_o=0 for exactly 3 cycles to cover master busy-flag latency, then goes to POLL.
REQ-017 POLL: spi_addr_o=0x8, spi_we_o=0; stays while spi_rdata_i[0]==1, else goes to CAPT.
REQ-018 CAPT: spi_addr_o=0x4; latches spi_rdata_i[7:0]; header bytes return to LOAD, or go to DESEL if the header is done and len is 0 (unreachable by REQ-012); data bytes go to OUT.
REQ-019 OUT: byte_valid_o=1 with the captured byte_o; the byte transfers when byte_valid_o && byte_ready_i; byte_o SHALL stay stable while stalled; after transfer, the remaining count decrements, going to LOAD if nonzero, else DESEL.
REQ-020 DESEL: writes CTRL with select=0 and start=0, then goes to FIN.
REQ-021 FIN: pulses done_o for one cycle, returns to IDLE.
REQ-022 spi_we_o SHALL be asserted only in SEL, LOAD, KICK and DESEL, for exactly one cycle each.
REQ-023 No writes SHALL occur in WAIT, POLL or CAPT, so the master's DATA update on completion is never blocked.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 Address arithmetic SHALL not wrap; the flash handles wrap at 2^24.

Reset
REQ-026 On rst_ni==0 at clk_i edge: state IDLE; busy_o=0; done_o=0; byte_valid_o=0; byte_o=8'h00; spi_we_o=0; spi_addr_o=0; spi_wdata_o=0.
REQ-027 Reset mid-transaction SHALL abandon it without a DESEL write; the master shares rst_ni and clears select itself.

Structure
REQ-028 A shared package spi_pkg SHALL hold the register offsets, CTRL bit positions, the FSM state enum and CMD_READ.
REQ-029 No sub-module is needed; the block is a single FSM with its counters.

Verification
REQ-030 With a spi master and a flash model: start, addr 24'h000100, len 4, memory 11 22 33 44 -> MOSI shows 03 00 01 00 00 00 00 00; stream gives 11,22,33,44; one done_o; select drops before done_o.
REQ-031 len_i=0 -> no register writes, done_o exactly 2 cycles after start_i, busy_o high for 1 cycle.
REQ-032 byte_ready_i held low 20 cycles on the second data byte -> byte_o stable, no further SPI activity until accepted, all bytes correct.
REQ-033 start_i re-pulsed while busy_o -> ignored, exactly one done_o.
REQ-034 rst_ni low for 1 cycle mid data phase -> all outputs at reset values next cycle; a new request (addr 24'h0, len 1) completes correctly.
REQ-035 DIV=8'd3 -> SPI clock 1/8 of clk_i, same data as REQ-030, poll loop lengthens with no extra writes.
